cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single 256-bit cacheline memory port between the icache and the dcache downward-facing ports.
- Sits between both caches' dfp interfaces and the memory or burst adapter.
- Grants one whole-line transaction at a time. Round-robin on contention. Registered request capture and response routing.
- Guarantees each cache sees exactly one resp per accepted request.

Parameters:
- ADDR_W, 32, address width (line-aligned; low 5 bits forced to 0 on the memory side)
- LINE_W, 256, cacheline data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- ic_dfp_addr  in  ADDR_W  icache request address
- ic_dfp_read  in  1  icache line read request (level, held until ic_dfp_resp)
- ic_dfp_write  in  1  icache line write request (held until ic_dfp_resp)
- ic_dfp_wdata  in  LINE_W  icache write data
- ic_dfp_rdata  out  LINE_W  read data to icache
- ic_dfp_resp  out  1  one-cycle completion pulse to icache
- dc_dfp_addr, dc_dfp_read, dc_dfp_write, dc_dfp_wdata  in  (same widths)  dcache request
- dc_dfp_rdata  out  LINE_W  read data to dcache
- dc_dfp_resp  out  1  completion pulse to dcache
- mem_addr  out  ADDR_W  memory address
- mem_read  out  1  memory read, held until mem_resp
- mem_write  out  1  memory write, held until mem_resp
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, BUSY_IC, BUSY_DC.
- Reset (rst=0, async):
  - state=IDLE; last_grant=DC, so the icache wins the first tie.
  - Request registers cleared.
  - mem_read, mem_write, ic_dfp_resp and dc_dfp_resp are 0; mem_addr, mem_wdata, ic_dfp_rdata and dc_dfp_rdata are 0.
- IDLE, one requester (read|write) at edge t:
  - Capture {addr[ADDR_W-1:5],5'b0, wdata, write} into the request register; go to BUSY_x.
  - mem_read or mem_write is asserted from cycle t+1 and driven from the register only. No combinational path from cache inputs to mem outputs.
- IDLE, both requesting: grant the one that is not last_grant; update last_grant on grant.
- BUSY_x:
  - Hold mem_* stable. Ignore all cache input changes.
  - On mem_resp=1:
    - x_dfp_resp=1 in the same cycle (combinational from mem_resp and state).
    - x_dfp_rdata=mem_rdata; the other cache's resp stays 0.
    - Next state IDLE. mem_read and mem_write deassert on that edge.
- rdata outputs: driven with mem_rdata only during resp, otherwise 0.
- Re-arbitration: earliest next grant is the cycle after resp. The cache drops or changes its request at the resp edge, so stale requests are never regranted.
- Latency: memory request issued 1 cycle after the cache asserts (uncontended). Worst-case wait is one full transaction of the other cache. Round-robin bounds starvation to one.
- Illegal input read&write simultaneously from one cache: treated as write; a simulation assertion fires.
- mem_resp in IDLE: ignored; simulation assertion.
- Reset mid-transaction: aborts immediately. Outputs go to their reset values. Any later mem_resp is ignored in IDLE.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs perf_ic_grants[31:0], perf_dc_grants[31:0] and perf_conflict_cycles[31:0].
  - Grant counters increment on each grant.
  - Conflict counter increments each cycle a requester is waiting while the other owns the port or wins the tie.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: no counters, no ports; function is otherwise identical.

Decomposition:
- Shared cache_types package:
  - arb_state_t enum {IDLE, BUSY_IC, BUSY_DC}.
  - arb_owner_t enum {OWN_IC, OWN_DC}.
  - mem_req_t struct {addr, wdata, write}.
  - LINE_BYTES=32 constant.
- One natural sub-module, rr_arb2: two-requester round-robin picker holding last_grant, with inputs req[1:0] and accept, output gnt[1:0] one-hot.

Test Plan:
- Icache read only of 0x0000_1234 → mem_read=1 and mem_addr=0x0000_1220 from the next cycle. After mem_resp with rdata=A, ic_dfp_resp=1 and ic_dfp_rdata=A; dc_dfp_resp stays 0.
- Both read in the same cycle right after reset → icache granted first. Dcache mem_read issued the cycle after ic_dfp_resp. Then, with both requesting again, the icache wins (last_grant=DC after the DC service).
- Dcache write 0x8000_0040 with wdata=W while the icache requests mid-transaction → mem_write, mem_addr and mem_wdata stay constant until mem_resp. The icache is served only afterwards.
- Icache requests continuously while the dcache requests → grants alternate IC, DC, IC, DC; no requester waits more than one transaction.
- rst pulled low while BUSY_DC → mem_read/mem_write go to 0 asynchronously. After release, a stray mem_resp produces no dfp_resp.
- With ARB_PERF_EN: 3 icache and 2 dcache transactions with one tie → perf_ic_grants=3, perf_dc_grants=2, and perf_conflict_cycles equal to the cycles the loser waited.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache-side types for the cacheline memory arbiter: FSM states,
// port owner, captured request format and line-alignment helper.
package cache_types;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_LINE_W = 256;
  localparam int LINE_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IC = 2'd1,
    BUSY_DC = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_LINE_W-1:0] wdata;
    logic                  write;
  } mem_req_t;

  // Clears the byte-offset bits so the memory side only ever sees whole lines.
  function automatic logic [REQ_ADDR_W-1:0] line_align(input logic [REQ_ADDR_W-1:0] a);
    return a & ~REQ_ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Whole-line request/response bus used both for the cache dfp ports and for
// the shared memory port. The requester side is the master.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Bit 0 is the icache, bit 1 the dcache.
// On a tie the requester that did not win last time is granted; the history
// only advances when the grant is actually taken (accept high).
module rr_arb2
  import cache_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  arb_owner_t last_grant_reg, last_grant_next;

  // One-hot pick; a tie goes to whoever did not own the port last.
  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req == 2'b11) begin
        gnt = (last_grant_reg == OWN_DC) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the winner of every taken grant.
  always_comb begin
    last_grant_next = last_grant_reg;
    if (gnt[0]) begin
      last_grant_next = OWN_IC;
    end else if (gnt[1]) begin
      last_grant_next = OWN_DC;
    end
  end

  // History register; starts as DC so the icache wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= OWN_DC;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single cacheline memory port between icache and dcache dfp
// ports. One whole-line transaction at a time, round-robin on contention.
// The memory request is driven only from the captured request register, so
// nothing on the cache side reaches mem_* combinationally.
// Optional build macro: ARB_PERF_EN adds grant and conflict counters.
module cache_mem_arbiter
  import cache_types::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int LINE_W = REQ_LINE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.slave   ic_dfp,
  cache_mem_arbiter_if.slave   dc_dfp,
  cache_mem_arbiter_if.master  mem
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]          perf_ic_grants,
  output logic [31:0]          perf_dc_grants,
  output logic [31:0]          perf_conflict_cycles
`endif
);

  arb_state_t state_reg, state_next;
  mem_req_t   req_reg, req_next;

  logic       ic_req, dc_req;
  logic       arb_accept;
  logic [1:0] gnt;
  logic       ic_resp, dc_resp;

  // A write flag wins over read, so read&write together is handled as a write.
  assign ic_req     = ic_dfp.read | ic_dfp.write;
  assign dc_req     = dc_dfp.read | dc_dfp.write;
  assign arb_accept = (state_reg == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({dc_req, ic_req}),
    .accept (arb_accept),
    .gnt    (gnt)
  );

  // Next state and request capture; in BUSY the cache inputs are ignored.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    unique case (state_reg)
      IDLE: begin
        if (gnt[0]) begin
          state_next     = BUSY_IC;
          req_next.addr  = line_align(ic_dfp.addr);
          req_next.wdata = ic_dfp.wdata;
          req_next.write = ic_dfp.write;
        end else if (gnt[1]) begin
          state_next     = BUSY_DC;
          req_next.addr  = line_align(dc_dfp.addr);
          req_next.wdata = dc_dfp.wdata;
          req_next.write = dc_dfp.write;
        end
      end
      BUSY_IC, BUSY_DC: begin
        if (mem.resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  // Memory side comes purely from registered state.
  assign mem.read  = (state_reg != IDLE) && !req_reg.write;
  assign mem.write = (state_reg != IDLE) &&  req_reg.write;
  assign mem.addr  = req_reg.addr[ADDR_W-1:0];
  assign mem.wdata = req_reg.wdata;

  // Response routing: only the owner sees the pulse and the data.
  assign ic_resp      = (state_reg == BUSY_IC) && mem.resp;
  assign dc_resp      = (state_reg == BUSY_DC) && mem.resp;
  assign ic_dfp.resp  = ic_resp;
  assign dc_dfp.resp  = dc_resp;
  assign ic_dfp.rdata = ic_resp ? mem.rdata : {LINE_W{1'b0}};
  assign dc_dfp.rdata = dc_resp ? mem.rdata : {LINE_W{1'b0}};

`ifdef ARB_PERF_EN
  logic [31:0] perf_ic_reg, perf_dc_reg, perf_conf_reg;
  logic        conflict;

  // A requester is held off while the other one owns the port or wins a tie.
  assign conflict = ((state_reg == BUSY_IC) && dc_req) ||
                    ((state_reg == BUSY_DC) && ic_req) ||
                    ((state_reg == IDLE) && ic_req && dc_req);

  // Free-running counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ic_reg   <= '0;
      perf_dc_reg   <= '0;
      perf_conf_reg <= '0;
    end else begin
      if (gnt[0]) perf_ic_reg <= perf_ic_reg + 32'd1;
      if (gnt[1]) perf_dc_reg <= perf_dc_reg + 32'd1;
      if (conflict) perf_conf_reg <= perf_conf_reg + 32'd1;
    end
  end

  assign perf_ic_grants       = perf_ic_reg;
  assign perf_dc_grants       = perf_dc_reg;
  assign perf_conflict_cycles = perf_conf_reg;
`endif

  // Simulation-only protocol checks on the cache and memory inputs.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(ic_dfp.read && ic_dfp.write))
        else $error("icache asserted read and write together; handled as write");
      assert (!(dc_dfp.read && dc_dfp.write))
        else $error("dcache asserted read and write together; handled as write");
      if (state_reg == IDLE) begin
        assert (!mem.resp)
          else $warning("mem_resp while idle; ignored");
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run;
  int   tests_failed;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) ic_dfp ();
  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) dc_dfp ();
  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) mem ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_ic, perf_dc, perf_conf;
`endif

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ic_dfp (ic_dfp),
    .dc_dfp (dc_dfp),
    .mem    (mem)
`ifdef ARB_PERF_EN
    ,
    .perf_ic_grants       (perf_ic),
    .perf_dc_grants       (perf_dc),
    .perf_conflict_cycles (perf_conf)
`endif
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic idle_inputs();
    ic_dfp.addr = '0; ic_dfp.read = 1'b0; ic_dfp.write = 1'b0; ic_dfp.wdata = '0;
    dc_dfp.addr = '0; dc_dfp.read = 1'b0; dc_dfp.write = 1'b0; dc_dfp.wdata = '0;
    mem.resp = 1'b0; mem.rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    ic_dfp.read = 1'b1; ic_dfp.addr = 32'hDEAD_BEE0;
    mem.resp = 1'b1; mem.rdata = rand_line();
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (mem.read !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read: got %0b want 0", mem.read); end
    tests_run++; if (mem.write !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_write: got %0b want 0", mem.write); end
    tests_run++; if (mem.addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", mem.addr); end
    tests_run++; if (mem.wdata !== '0) begin tests_failed++; $display("FAIL reset_mem_wdata: got nonzero want 0"); end
    tests_run++; if (ic_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL reset_ic_resp: got %0b want 0", ic_dfp.resp); end
    tests_run++; if (dc_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_resp: got %0b want 0", dc_dfp.resp); end
    tests_run++; if (ic_dfp.rdata !== '0) begin tests_failed++; $display("FAIL reset_ic_rdata: got nonzero want 0"); end
    tests_run++; if (dc_dfp.rdata !== '0) begin tests_failed++; $display("FAIL reset_dc_rdata: got nonzero want 0"); end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset: outputs idle with requests and mem_resp held during reset");
  endtask

  task automatic test_ic_read();
    logic [LW-1:0] a;
    do_reset();
    ic_dfp.addr = 32'h0000_1234; ic_dfp.read = 1'b1;
    #1;
    tests_run++; if (mem.read !== 1'b0) begin tests_failed++; $display("FAIL icrd_no_comb_path: got %0b want 0", mem.read); end
    @(negedge clk);
    tests_run++; if (mem.read !== 1'b1) begin tests_failed++; $display("FAIL icrd_mem_read: got %0b want 1", mem.read); end
    tests_run++; if (mem.write !== 1'b0) begin tests_failed++; $display("FAIL icrd_mem_write: got %0b want 0", mem.write); end
    tests_run++; if (mem.addr !== 32'h0000_1220) begin tests_failed++; $display("FAIL icrd_mem_addr: got %h want 00001220", mem.addr); end
    repeat (2) @(negedge clk);
    tests_run++; if (mem.addr !== 32'h0000_1220) begin tests_failed++; $display("FAIL icrd_addr_hold: got %h want 00001220", mem.addr); end
    tests_run++; if (ic_dfp.rdata !== '0) begin tests_failed++; $display("FAIL icrd_rdata_before_resp: got nonzero want 0"); end
    a = rand_line();
    mem.rdata = a; mem.resp = 1'b1;
    #1;
    tests_run++; if (ic_dfp.resp !== 1'b1) begin tests_failed++; $display("FAIL icrd_ic_resp: got %0b want 1", ic_dfp.resp); end
    tests_run++; if (ic_dfp.rdata !== a) begin tests_failed++; $display("FAIL icrd_ic_rdata: got %h want %h", ic_dfp.rdata[31:0], a[31:0]); end
    tests_run++; if (dc_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL icrd_dc_resp: got %0b want 0", dc_dfp.resp); end
    tests_run++; if (dc_dfp.rdata !== '0) begin tests_failed++; $display("FAIL icrd_dc_rdata: got nonzero want 0"); end
    @(negedge clk);
    mem.resp = 1'b0; mem.rdata = '0; ic_dfp.read = 1'b0;
    tests_run++; if (mem.read !== 1'b0) begin tests_failed++; $display("FAIL icrd_read_drop: got %0b want 0", mem.read); end
    tests_run++; if (ic_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL icrd_resp_one_cycle: got %0b want 0", ic_dfp.resp); end
    $display("[TB] txn ic read addr=00001234 -> mem addr 00001220");
  endtask

  task automatic test_tie();
    logic [LW-1:0] a;
    do_reset();
    ic_dfp.addr = 32'h0000_0100; ic_dfp.read = 1'b1;
    dc_dfp.addr = 32'h0000_0200; dc_dfp.read = 1'b1;
    @(negedge clk);
    tests_run++; if (mem.addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL tie1_ic_first: got %h want 00000100", mem.addr); end
    a = rand_line(); mem.rdata = a; mem.resp = 1'b1;
    #1;
    tests_run++; if ({ic_dfp.resp, dc_dfp.resp} !== 2'b10) begin tests_failed++; $display("FAIL tie1_resp: got %b want 10", {ic_dfp.resp, dc_dfp.resp}); end
    @(negedge clk);
    mem.resp = 1'b0; ic_dfp.read = 1'b0;
    tests_run++; if (mem.read !== 1'b0) begin tests_failed++; $display("FAIL tie1_gap: got %0b want 0", mem.read); end
    @(negedge clk);
    tests_run++; if (mem.read !== 1'b1 || mem.addr !== 32'h0000_0200) begin tests_failed++; $display("FAIL tie1_dc_next: got rd=%0b addr=%h want rd=1 addr=00000200", mem.read, mem.addr); end
    a = rand_line(); mem.rdata = a; mem.resp = 1'b1;
    #1;
    tests_run++; if (dc_dfp.resp !== 1'b1 || dc_dfp.rdata !== a || ic_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL tie1_dc_resp: got ic=%0b dc=%0b want ic=0 dc=1", ic_dfp.resp, dc_dfp.resp); end
    @(negedge clk);
    mem.resp = 1'b0; dc_dfp.read = 1'b0;
    ic_dfp.addr = 32'h0000_0300; ic_dfp.read = 1'b1;
    dc_dfp.addr = 32'h0000_0400; dc_dfp.read = 1'b1;
    @(negedge clk);
    tests_run++; if (mem.addr !== 32'h0000_0300) begin tests_failed++; $display("FAIL tie2_ic_wins: got %h want 00000300", mem.addr); end
    $display("[TB] txn tie: ic, dc, then ic wins second tie");
    idle_inputs();
  endtask

  task automatic test_dc_write_hold();
    logic [LW-1:0] w, a;
    do_reset();
    w = rand_line();
    dc_dfp.addr = 32'h8000_0040; dc_dfp.write = 1'b1; dc_dfp.wdata = w;
    @(negedge clk);
    ic_dfp.addr = 32'h0000_0500; ic_dfp.read = 1'b1;
    dc_dfp.addr = 32'hFFFF_FFFF; dc_dfp.wdata = rand_line();
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (mem.write !== 1'b1 || mem.read !== 1'b0) begin tests_failed++; $display("FAIL dcwr_cmd_%0d: got rd=%0b wr=%0b want rd=0 wr=1", k, mem.read, mem.write); end
      tests_run++; if (mem.addr !== 32'h8000_0040) begin tests_failed++; $display("FAIL dcwr_addr_%0d: got %h want 80000040", k, mem.addr); end
      tests_run++; if (mem.wdata !== w) begin tests_failed++; $display("FAIL dcwr_wdata_%0d: got %h want %h", k, mem.wdata[31:0], w[31:0]); end
      @(negedge clk);
    end
    a = rand_line(); mem.rdata = a; mem.resp = 1'b1;
    #1;
    tests_run++; if ({ic_dfp.resp, dc_dfp.resp} !== 2'b01) begin tests_failed++; $display("FAIL dcwr_resp: got %b want 01", {ic_dfp.resp, dc_dfp.resp}); end
    @(negedge clk);
    mem.resp = 1'b0; dc_dfp.write = 1'b0;
    tests_run++; if (mem.read !== 1'b0 || mem.write !== 1'b0) begin tests_failed++; $display("FAIL dcwr_idle: got rd=%0b wr=%0b want 0 0", mem.read, mem.write); end
    @(negedge clk);
    tests_run++; if (mem.read !== 1'b1 || mem.addr !== 32'h0000_0500) begin tests_failed++; $display("FAIL dcwr_ic_after: got rd=%0b addr=%h want rd=1 addr=00000500", mem.read, mem.addr); end
    $display("[TB] txn dc write addr=80000040 held stable, ic served after");
    idle_inputs();
  endtask

  task automatic test_alternate();
    logic [AW-1:0] ia, da, ea;
    logic [LW-1:0] rd;
    logic exp_ic;
    do_reset();
    ia = $urandom(); da = $urandom();
    ic_dfp.addr = ia; ic_dfp.read = 1'b1;
    dc_dfp.addr = da; dc_dfp.read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_ic = (k % 2 == 0);
      ea = exp_ic ? {ia[AW-1:5], 5'b0} : {da[AW-1:5], 5'b0};
      tests_run++; if (mem.read !== 1'b1 || mem.addr !== ea) begin tests_failed++; $display("FAIL alt_grant_%0d: got rd=%0b addr=%h want rd=1 addr=%h", k, mem.read, mem.addr, ea); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rd = rand_line(); mem.rdata = rd; mem.resp = 1'b1;
      #1;
      tests_run++; if (ic_dfp.resp !== exp_ic || dc_dfp.resp !== !exp_ic) begin tests_failed++; $display("FAIL alt_resp_%0d: got ic=%0b dc=%0b want ic=%0b", k, ic_dfp.resp, dc_dfp.resp, exp_ic); end
      $display("[TB] txn alternate %0d owner=%s addr=%h", k, exp_ic ? "ic" : "dc", ea);
      @(negedge clk);
      mem.resp = 1'b0; mem.rdata = '0;
      if (exp_ic) begin ia = $urandom(); ic_dfp.addr = ia; end
      else begin da = $urandom(); dc_dfp.addr = da; end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] rd;
    do_reset();
    dc_dfp.addr = 32'h0000_2000; dc_dfp.read = 1'b1;
    @(negedge clk);
    tests_run++; if (mem.read !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy: got %0b want 1", mem.read); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (mem.read !== 1'b0 || mem.write !== 1'b0) begin tests_failed++; $display("FAIL rstmid_async: got rd=%0b wr=%0b want 0 0", mem.read, mem.write); end
    tests_run++; if (mem.addr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_addr: got %h want 0", mem.addr); end
    dc_dfp.read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd = rand_line(); mem.rdata = rd; mem.resp = 1'b1;
    #1;
    tests_run++; if (ic_dfp.resp !== 1'b0 || dc_dfp.resp !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stray: got ic=%0b dc=%0b want 0 0", ic_dfp.resp, dc_dfp.resp); end
    tests_run++; if (dc_dfp.rdata !== '0) begin tests_failed++; $display("FAIL rstmid_rdata: got nonzero want 0"); end
    @(negedge clk);
    mem.resp = 1'b0;
    tests_run++; if (mem.read !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle: got %0b want 0", mem.read); end
    $display("[TB] txn dc read aborted by reset, stray mem_resp ignored");
  endtask

  task automatic test_random();
    logic          act[2], wr[2], done[2];
    logic [AW-1:0] ca[2];
    logic [LW-1:0] cw[2];
    int            gap[2], seen[2], served[2];
    int            owner, last, lat, total, win;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, rd;
    logic          e_wr, rsp;
    do_reset();
    owner = 0; last = 2; lat = 0; total = 0;
    e_addr = '0; e_wdata = '0; e_wr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      act[c] = 1'b0; wr[c] = 1'b0; done[c] = 1'b0; ca[c] = '0; cw[c] = '0;
      gap[c] = $urandom_range(0, 2); seen[c] = 0; served[c] = 0;
    end
    for (int cyc = 0; cyc < 4000 && total < 40; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (done[c]) begin act[c] = 1'b0; done[c] = 1'b0; gap[c] = $urandom_range(0, 2); end
        if (!act[c]) begin
          if (gap[c] == 0) begin
            act[c] = 1'b1; ca[c] = $urandom(); wr[c] = 1'($urandom_range(0, 1)); cw[c] = rand_line();
          end else gap[c]--;
        end else if (owner == c + 1 && $urandom_range(0, 2) == 0) begin
          ca[c] = $urandom(); cw[c] = rand_line();
        end
      end
      ic_dfp.addr = ca[0]; ic_dfp.read = act[0] && !wr[0]; ic_dfp.write = act[0] && wr[0]; ic_dfp.wdata = cw[0];
      dc_dfp.addr = ca[1]; dc_dfp.read = act[1] && !wr[1]; dc_dfp.write = act[1] && wr[1]; dc_dfp.wdata = cw[1];
      tests_run++; if (mem.read !== (owner != 0 && !e_wr) || mem.write !== (owner != 0 && e_wr)) begin tests_failed++; $display("FAIL rnd_cmd cyc%0d: got rd=%0b wr=%0b owner=%0d", cyc, mem.read, mem.write, owner); end
      if (owner != 0) begin
        tests_run++; if (mem.addr !== e_addr) begin tests_failed++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, mem.addr, e_addr); end
        if (e_wr) begin
          tests_run++; if (mem.wdata !== e_wdata) begin tests_failed++; $display("FAIL rnd_wdata cyc%0d: got %h want %h", cyc, mem.wdata[31:0], e_wdata[31:0]); end
        end
      end
      rsp = (owner != 0) && (lat == 0);
      if (owner != 0 && lat > 0) lat--;
      rd = rand_line(); mem.rdata = rd; mem.resp = rsp;
      #1;
      tests_run++; if (ic_dfp.resp !== (rsp && owner == 1) || dc_dfp.resp !== (rsp && owner == 2)) begin tests_failed++; $display("FAIL rnd_resp cyc%0d: got ic=%0b dc=%0b owner=%0d rsp=%0b", cyc, ic_dfp.resp, dc_dfp.resp, owner, rsp); end
      tests_run++; if (ic_dfp.rdata !== ((rsp && owner == 1) ? rd : '0) || dc_dfp.rdata !== ((rsp && owner == 2) ? rd : '0)) begin tests_failed++; $display("FAIL rnd_rdata cyc%0d: got ic=%h dc=%h want %h on owner %0d", cyc, ic_dfp.rdata[31:0], dc_dfp.rdata[31:0], rd[31:0], owner); end
      if (ic_dfp.resp === 1'b1) seen[0]++;
      if (dc_dfp.resp === 1'b1) seen[1]++;
      if (rsp) begin
        done[owner-1] = 1'b1; served[owner-1]++; total++;
        $display("[TB] txn random %0d owner=%s %s addr=%h", total, owner == 1 ? "ic" : "dc", e_wr ? "write" : "read", e_addr);
        owner = 0;
      end else if (owner == 0) begin
        win = 0;
        if (act[0] && act[1]) win = (last == 2) ? 1 : 2;
        else if (act[0]) win = 1;
        else if (act[1]) win = 2;
        if (win != 0) begin
          owner = win; last = win;
          e_addr = {ca[win-1][AW-1:5], 5'b0}; e_wr = wr[win-1]; e_wdata = cw[win-1];
          lat = $urandom_range(0, 3);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    tests_run++; if (total < 40) begin tests_failed++; $display("FAIL rnd_budget: got %0d transactions want 40", total); end
    tests_run++; if (seen[0] != served[0] || seen[1] != served[1]) begin tests_failed++; $display("FAIL rnd_resp_count: got ic=%0d dc=%0d want ic=%0d dc=%0d", seen[0], seen[1], served[0], served[1]); end
  endtask

`ifdef ARB_PERF_EN
  task automatic single_txn(input bit is_ic, input logic [AW-1:0] a);
    if (is_ic) begin ic_dfp.addr = a; ic_dfp.read = 1'b1; end
    else begin dc_dfp.addr = a; dc_dfp.read = 1'b1; end
    @(negedge clk);
    mem.resp = 1'b1;
    @(negedge clk);
    mem.resp = 1'b0; ic_dfp.read = 1'b0; dc_dfp.read = 1'b0;
    $display("[TB] txn perf %s addr=%h", is_ic ? "ic" : "dc", a);
  endtask

  task automatic test_perf();
    do_reset();
    ic_dfp.addr = 32'h40; ic_dfp.read = 1'b1;
    dc_dfp.addr = 32'h80; dc_dfp.read = 1'b1;
    @(negedge clk);
    mem.resp = 1'b1;
    @(negedge clk);
    mem.resp = 1'b0; ic_dfp.read = 1'b0;
    @(negedge clk);
    mem.resp = 1'b1;
    @(negedge clk);
    mem.resp = 1'b0; dc_dfp.read = 1'b0;
    $display("[TB] txn perf tie ic then dc");
    single_txn(1'b1, 32'hC0);
    single_txn(1'b0, 32'h100);
    single_txn(1'b1, 32'h140);
    @(negedge clk);
    tests_run++; if (perf_ic !== 32'd3) begin tests_failed++; $display("FAIL perf_ic: got %0d want 3", perf_ic); end
    tests_run++; if (perf_dc !== 32'd2) begin tests_failed++; $display("FAIL perf_dc: got %0d want 2", perf_dc); end
    tests_run++; if (perf_conf !== 32'd2) begin tests_failed++; $display("FAIL perf_conflict: got %0d want 2", perf_conf); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ic_read();
    test_tie();
    test_dc_write_hold();
    test_alternate();
    test_reset_mid();
    test_random();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
